// File: rtl/axi4lite_reg_slave_if.sv
// AXI4-Lite bus bundle between a bus master and axi4lite_reg_slave.
// Clock and reset are plain module ports and are not part of this bundle.
interface axi4lite_reg_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                      AWVALID;
  logic                      AWREADY;
  logic [ADDR_WIDTH-1:0]     AWADDR;
  logic [2:0]                AWPROT;
  logic                      WVALID;
  logic                      WREADY;
  logic [DATA_WIDTH-1:0]     WDATA;
  logic [DATA_WIDTH/8-1:0]   WSTRB;
  logic                      BVALID;
  logic                      BREADY;
  logic [1:0]                BRESP;
  logic                      ARVALID;
  logic                      ARREADY;
  logic [ADDR_WIDTH-1:0]     ARADDR;
  logic [2:0]                ARPROT;
  logic                      RVALID;
  logic                      RREADY;
  logic [DATA_WIDTH-1:0]     RDATA;
  logic [1:0]                RRESP;

  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
    output ARVALID, ARADDR, ARPROT, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
    input  ARVALID, ARADDR, ARPROT, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite register bank with byte strobes and per-register write pulses.
// Define AXI4LITE_REG_SLAVE_DECERR_EN to answer out-of-range accesses with DECERR.
module axi4lite_reg_slave #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  axi4lite_reg_slave_if.slave            axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - LSB;

`ifdef AXI4LITE_REG_SLAVE_DECERR_EN
  localparam logic [1:0] OOR_RESP = 2'b11;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return 64'(idx) < 64'(NUM_REGS);
  endfunction

  logic                  aw_full_reg;
  logic [IDX_W-1:0]      aw_idx_reg;
  logic                  w_full_reg;
  logic [DATA_WIDTH-1:0] w_data_reg;
  logic [STRB_W-1:0]     w_strb_reg;
  logic                  bvalid_reg;
  logic [1:0]            bresp_reg;
  logic                  rvalid_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [1:0]            rresp_reg;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic [IDX_W-1:0]      ar_idx;
  logic [DATA_WIDTH-1:0] rd_mux;

  assign axi.AWREADY = !aw_full_reg;
  assign axi.WREADY  = !w_full_reg;
  assign axi.BVALID  = bvalid_reg;
  assign axi.BRESP   = bresp_reg;
  assign axi.ARREADY = !rvalid_reg;
  assign axi.RVALID  = rvalid_reg;
  assign axi.RDATA   = rdata_reg;
  assign axi.RRESP   = rresp_reg;

  assign aw_hs  = axi.AWVALID && !aw_full_reg;
  assign w_hs   = axi.WVALID && !w_full_reg;
  assign ar_hs  = axi.ARVALID && !rvalid_reg;
  // A pending response blocks the commit; the next pair waits in the slots.
  assign commit = aw_full_reg && w_full_reg && !bvalid_reg;
  assign ar_idx = axi.ARADDR[ADDR_WIDTH-1:LSB];

  logic unused_bits;
  assign unused_bits = ^{axi.AWPROT, axi.ARPROT, axi.AWADDR[LSB-1:0], axi.ARADDR[LSB-1:0]};

  // Write holding slots; commit only happens while both are full, so it never
  // coincides with a handshake on either slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full_reg <= 1'b0;
      aw_idx_reg  <= '0;
      w_full_reg  <= 1'b0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
    end else begin
      if (commit) begin
        aw_full_reg <= 1'b0;
        w_full_reg  <= 1'b0;
      end
      if (aw_hs) begin
        aw_full_reg <= 1'b1;
        aw_idx_reg  <= axi.AWADDR[ADDR_WIDTH-1:LSB];
      end
      if (w_hs) begin
        w_full_reg <= 1'b1;
        w_data_reg <= axi.WDATA;
        w_strb_reg <= axi.WSTRB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bvalid_reg <= 1'b0;
      bresp_reg  <= 2'b00;
    end else if (commit) begin
      bvalid_reg <= 1'b1;
      bresp_reg  <= in_range(aw_idx_reg) ? 2'b00 : OOR_RESP;
    end else if (axi.BREADY) begin
      bvalid_reg <= 1'b0;
    end
  end

  // Out-of-range indices match no register and fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) rd_mux = regs[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      rresp_reg  <= 2'b00;
    end else if (ar_hs) begin
      rvalid_reg <= 1'b1;
      rdata_reg  <= rd_mux;
      rresp_reg  <= in_range(ar_idx) ? 2'b00 : OOR_RESP;
    end else if (axi.RREADY) begin
      rvalid_reg <= 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic                  hit;
      logic [DATA_WIDTH-1:0] q_reg;
      logic                  pulse_reg;

      assign hit = commit && (aw_idx_reg == IDX_W'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          q_reg     <= RESET_VALUE;
          pulse_reg <= 1'b0;
        end else begin
          pulse_reg <= hit;
          for (int bi = 0; bi < STRB_W; bi++) begin
            if (hit && w_strb_reg[bi]) q_reg[bi*8 +: 8] <= w_data_reg[bi*8 +: 8];
          end
        end
      end

      assign regs[gi*DATA_WIDTH +: DATA_WIDTH] = q_reg;
      assign wr_pulse[gi]                      = pulse_reg;
    end
  endgenerate

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Self-checking bench for axi4lite_reg_slave: directed scenarios plus a
// randomized mix checked against an array model of the register bank.
module tb_axi4lite_reg_slave;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 16;

`ifdef AXI4LITE_REG_SLAVE_DECERR_EN
  localparam logic [1:0] OOR_RESP = 2'b11;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic             clk;
  logic             rst;
  logic [NR*DW-1:0] dut_regs;
  logic [NR-1:0]    dut_pulse;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] model [NR];

  axi4lite_reg_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  axi4lite_reg_slave #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .RESET_VALUE('0)
  ) dut (
    .clk(clk), .rst(rst), .axi(bus), .regs(dut_regs), .wr_pulse(dut_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NR*DW-1:0] exp_flat();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = model[i];
    return v;
  endfunction

  function automatic void model_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                      input logic [3:0] strb);
    int idx;
    idx = int'(addr >> 2);
    if (idx < NR) begin
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
    end
  endfunction

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          output logic [1:0] resp, output logic [NR-1:0] pulse,
                          output logic [NR-1:0] pulse_after, output logic timeout);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0; timeout = 0;
    resp = 'x; pulse = 'x; pulse_after = 'x;
    bus.AWADDR = addr; bus.WDATA = data; bus.WSTRB = strb; bus.BREADY = 1'b0;
    while (!(aw_done && w_done) && cyc < 200) begin
      if (!aw_done && cyc >= aw_dly) bus.AWVALID = 1'b1;
      if (!w_done && cyc >= w_dly) bus.WVALID = 1'b1;
      aw_hs = bus.AWVALID && bus.AWREADY;
      w_hs  = bus.WVALID && bus.WREADY;
      @(negedge clk);
      cyc++;
      if (aw_hs) begin aw_done = 1; bus.AWVALID = 1'b0; end
      if (w_hs)  begin w_done = 1;  bus.WVALID = 1'b0;  end
    end
    cyc = 0;
    while (!bus.BVALID && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.BVALID) begin
      timeout = 1;
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    end else begin
      resp  = bus.BRESP;
      pulse = dut_pulse;
      bus.BREADY = 1'b1;
      @(negedge clk);
      bus.BREADY = 1'b0;
      pulse_after = dut_pulse;
    end
    $display("[TB] WR addr=%h data=%h strb=%h resp=%b pulse=%h timeout=%0d",
             addr, data, strb, resp, pulse, timeout);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                         output logic [1:0] resp, output logic lat_ok, output logic timeout);
    bit hs;
    int cyc;
    cyc = 0; hs = 0; timeout = 0; data = 'x; resp = 'x; lat_ok = 0;
    bus.ARADDR = addr; bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
    while (!hs && cyc < 200) begin
      hs = bus.ARREADY;
      @(negedge clk);
      cyc++;
    end
    bus.ARVALID = 1'b0;
    if (!hs) begin
      timeout = 1;
    end else begin
      lat_ok = bus.RVALID;
      data   = bus.RDATA;
      resp   = bus.RRESP;
      bus.RREADY = 1'b1;
      @(negedge clk);
      bus.RREADY = 1'b0;
    end
    $display("[TB] RD addr=%h data=%h resp=%b timeout=%0d", addr, data, resp, timeout);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NR; i++) model[i] = '0;
    tests_run++;
    if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b111) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b expected 111", {bus.AWREADY, bus.WREADY, bus.ARREADY});
    end
    tests_run++;
    if ({bus.BVALID, bus.RVALID, dut_pulse} !== '0) begin
      tests_failed++;
      $display("FAIL reset_valid: got b=%b r=%b pulse=%h expected 0", bus.BVALID, bus.RVALID, dut_pulse);
    end
    tests_run++;
    if ({bus.BRESP, bus.RRESP, bus.RDATA} !== '0) begin
      tests_failed++;
      $display("FAIL reset_resp: got bresp=%b rresp=%b rdata=%h expected 0", bus.BRESP, bus.RRESP, bus.RDATA);
    end
    tests_run++;
    if (dut_regs !== exp_flat()) begin
      tests_failed++;
      $display("FAIL reset_regs: got %h expected all zero", dut_regs);
    end
  endtask

  task automatic test_reset_mid();
    bus.AWADDR = 32'h10; bus.AWVALID = 1'b1;
    @(negedge clk);
    bus.AWVALID = 1'b0;
    tests_run++;
    if (bus.AWREADY !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_aw_capture: AWREADY got %b expected 0", bus.AWREADY);
    end
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    tests_run++;
    if (bus.AWREADY !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reset_drop: AWREADY got %b expected 1", bus.AWREADY);
    end
    bus.WDATA = 32'hCAFE0001; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    @(negedge clk);
    bus.WVALID = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.BVALID !== 1'b0 || dut_regs !== exp_flat()) begin
      tests_failed++;
      $display("FAIL mid_no_commit: BVALID got %b expected 0, regs[4] got %h expected %h",
               bus.BVALID, dut_regs[4*DW +: DW], model[4]);
    end
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
  endtask

  task automatic test_basic_write();
    logic [1:0] resp; logic [NR-1:0] p, pa; logic to, lat; logic [DW-1:0] d;
    bus.AWADDR = 32'h8; bus.WDATA = 32'hDEADBEEF; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.BREADY = 1'b0;
    @(negedge clk);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    tests_run++;
    if (bus.BVALID !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_b_early: BVALID got %b expected 0", bus.BVALID);
    end
    @(negedge clk);
    tests_run++;
    if (bus.BVALID !== 1'b1 || bus.BRESP !== 2'b00 || dut_pulse !== 16'h0004) begin
      tests_failed++;
      $display("FAIL basic_commit: BVALID=%b BRESP=%b pulse=%h expected 1 00 0004",
               bus.BVALID, bus.BRESP, dut_pulse);
    end
    tests_run++;
    if (dut_regs[2*DW +: DW] !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL basic_reg2: got %h expected deadbeef", dut_regs[2*DW +: DW]);
    end
    model[2] = 32'hDEADBEEF;
    bus.BREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0;
    tests_run++;
    if (bus.BVALID !== 1'b0 || dut_pulse !== '0) begin
      tests_failed++;
      $display("FAIL basic_b_clear: BVALID=%b pulse=%h expected 0 0000", bus.BVALID, dut_pulse);
    end
    $display("[TB] WR addr=00000008 data=deadbeef strb=f (cycle-exact)");

    do_write(32'h8, 32'h000000AA, 4'h1, 0, 0, resp, p, pa, to);
    model_write(32'h8, 32'h000000AA, 4'h1);
    tests_run++;
    if (to || resp !== 2'b00 || dut_regs[2*DW +: DW] !== 32'hDEADBEAA) begin
      tests_failed++;
      $display("FAIL strobe_write: to=%0d resp=%b reg2=%h expected 0 00 deadbeaa",
               to, resp, dut_regs[2*DW +: DW]);
    end
    do_read(32'h8, d, resp, lat, to);
    tests_run++;
    if (to || !lat || d !== 32'hDEADBEAA || resp !== 2'b00) begin
      tests_failed++;
      $display("FAIL read_back: to=%0d lat=%b rdata=%h rresp=%b expected 0 1 deadbeaa 00",
               to, lat, d, resp);
    end
  endtask

  task automatic test_early_w();
    bus.WDATA = 32'h1234; bus.WSTRB = 4'hF; bus.WVALID = 1'b1; bus.BREADY = 1'b0;
    @(negedge clk);
    bus.WVALID = 1'b0;
    tests_run++;
    if (bus.WREADY !== 1'b0) begin
      tests_failed++;
      $display("FAIL early_w_ready: WREADY got %b expected 0", bus.WREADY);
    end
    repeat (2) @(negedge clk);
    bus.AWADDR = 32'h0; bus.AWVALID = 1'b1;
    @(negedge clk);
    bus.AWVALID = 1'b0;
    tests_run++;
    if (bus.BVALID !== 1'b0) begin
      tests_failed++;
      $display("FAIL early_w_latency: BVALID got %b expected 0 at AW handshake", bus.BVALID);
    end
    @(negedge clk);
    model[0] = 32'h1234;
    tests_run++;
    if (bus.BVALID !== 1'b1 || dut_regs[0 +: DW] !== 32'h1234) begin
      tests_failed++;
      $display("FAIL early_w_commit: BVALID=%b reg0=%h expected 1 00001234", bus.BVALID, dut_regs[0 +: DW]);
    end
    bus.BREADY = 1'b1; @(negedge clk); bus.BREADY = 1'b0;
    $display("[TB] WR addr=00000000 data=00001234 strb=f (W before AW)");
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d1, d2;
    logic [NR*DW-1:0] snap;
    d1 = $urandom; d2 = $urandom;
    bus.AWADDR = 32'hC; bus.WDATA = d1; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.BREADY = 1'b0;
    @(negedge clk);
    bus.AWADDR = 32'h14; bus.WDATA = d2;
    @(negedge clk);
    model[3] = d1;
    @(negedge clk);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    snap = exp_flat();
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.AWREADY !== 1'b0 || bus.WREADY !== 1'b0 || bus.BVALID !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_held: AWREADY=%b WREADY=%b BVALID=%b expected 0 0 1",
               bus.AWREADY, bus.WREADY, bus.BVALID);
    end
    tests_run++;
    if (dut_regs !== snap || dut_pulse !== '0) begin
      tests_failed++;
      $display("FAIL b2b_no_commit: reg5=%h expected %h pulse=%h expected 0",
               dut_regs[5*DW +: DW], model[5], dut_pulse);
    end
    bus.BREADY = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.BVALID !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_b_clear: BVALID got %b expected 0", bus.BVALID);
    end
    @(negedge clk);
    model[5] = d2;
    tests_run++;
    if (bus.BVALID !== 1'b1 || dut_pulse !== 16'h0020 || dut_regs !== exp_flat()) begin
      tests_failed++;
      $display("FAIL b2b_second: BVALID=%b pulse=%h reg5=%h expected 1 0020 %h",
               bus.BVALID, dut_pulse, dut_regs[5*DW +: DW], d2);
    end
    @(negedge clk);
    bus.BREADY = 1'b0;
    $display("[TB] WR pair addr=0000000c/00000014 data=%h/%h (B back-pressure)", d1, d2);
  endtask

  task automatic test_same_edge_rw();
    logic [1:0] resp; logic [NR-1:0] p, pa; logic to, lat; logic [DW-1:0] d;
    do_write(32'h4, 32'h0, 4'hF, 0, 0, resp, p, pa, to);
    model_write(32'h4, 32'h0, 4'hF);
    bus.AWADDR = 32'h4; bus.WDATA = 32'h55; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.BREADY = 1'b0;
    @(negedge clk);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    bus.ARADDR = 32'h4; bus.ARVALID = 1'b1;
    @(negedge clk);
    bus.ARVALID = 1'b0;
    tests_run++;
    if (bus.RVALID !== 1'b1 || bus.RDATA !== 32'h0 || bus.BVALID !== 1'b1) begin
      tests_failed++;
      $display("FAIL same_edge_old: RVALID=%b RDATA=%h BVALID=%b expected 1 00000000 1",
               bus.RVALID, bus.RDATA, bus.BVALID);
    end
    model_write(32'h4, 32'h55, 4'hF);
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    @(negedge clk);
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;
    $display("[TB] WR+RD addr=00000004 same edge");
    do_read(32'h4, d, resp, lat, to);
    tests_run++;
    if (to || d !== 32'h55) begin
      tests_failed++;
      $display("FAIL same_edge_new: to=%0d rdata=%h expected 00000055", to, d);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp; logic [NR-1:0] p, pa; logic to, lat; logic [DW-1:0] d;
    logic [NR*DW-1:0] snap;
    snap = exp_flat();
    do_write(32'h40, $urandom, 4'hF, 0, 0, resp, p, pa, to);
    tests_run++;
    if (to || resp !== OOR_RESP || p !== '0 || dut_regs !== snap) begin
      tests_failed++;
      $display("FAIL oor_write: to=%0d bresp=%b expected %b pulse=%h expected 0", to, resp, OOR_RESP, p);
    end
    do_read(32'h40, d, resp, lat, to);
    tests_run++;
    if (to || d !== '0 || resp !== OOR_RESP) begin
      tests_failed++;
      $display("FAIL oor_read: to=%0d rdata=%h rresp=%b expected 0 %b", to, d, resp, OOR_RESP);
    end
    do_write(32'h3F, 32'hA5A55A5A, 4'hF, 1, 0, resp, p, pa, to);
    model_write(32'h3F, 32'hA5A55A5A, 4'hF);
    tests_run++;
    if (to || resp !== 2'b00 || p !== 16'h8000 || pa !== '0 || dut_regs !== exp_flat()) begin
      tests_failed++;
      $display("FAIL last_reg_write: to=%0d bresp=%b pulse=%h after=%h reg15=%h expected 00 8000 0000 a5a55a5a",
               to, resp, p, pa, dut_regs[15*DW +: DW]);
    end
  endtask

  task automatic test_random();
    logic [1:0] resp; logic [NR-1:0] p, pa, ep; logic to, lat; logic [DW-1:0] d, ed, data;
    logic [AW-1:0] addr; logic [3:0] strb; int idx;
    for (int n = 0; n < 60; n++) begin
      addr = AW'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      idx  = int'(addr >> 2);
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom; strb = 4'($urandom_range(0, 15));
        do_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), resp, p, pa, to);
        model_write(addr, data, strb);
        ep = (idx < NR) ? NR'(1) << idx : '0;
        tests_run++;
        if (to || resp !== ((idx < NR) ? 2'b00 : OOR_RESP) || p !== ep || pa !== '0
            || dut_regs !== exp_flat()) begin
          tests_failed++;
          $display("FAIL rand_write %0d: to=%0d bresp=%b pulse=%h exp_pulse=%h after=%h reg=%h exp=%h",
                   n, to, resp, p, ep, pa, (idx < NR) ? dut_regs[idx*DW +: DW] : '0,
                   (idx < NR) ? model[idx] : '0);
        end
      end else begin
        ed = (idx < NR) ? model[idx] : '0;
        do_read(addr, d, resp, lat, to);
        tests_run++;
        if (to || !lat || d !== ed || resp !== ((idx < NR) ? 2'b00 : OOR_RESP)) begin
          tests_failed++;
          $display("FAIL rand_read %0d: to=%0d lat=%b rdata=%h expected %h rresp=%b",
                   n, to, lat, d, ed, resp);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.AWVALID = 1'b0; bus.AWADDR = '0; bus.AWPROT = '0;
    bus.WVALID = 1'b0;  bus.WDATA = '0;  bus.WSTRB = '0;
    bus.BREADY = 1'b0;
    bus.ARVALID = 1'b0; bus.ARADDR = '0; bus.ARPROT = '0;
    bus.RREADY = 1'b0;
    test_reset();
    test_reset_mid();
    test_basic_write();
    test_early_w();
    test_back_to_back();
    test_same_edge_rw();
    test_out_of_range();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
